// File: rtl/aes_pkg.sv
// Shared constants and FSM state type for the iterative AES round controller.
package aes_pkg;

   localparam int AES_BLOCK_W = 128;
   localparam int AES_NR      = 10;
   localparam int AES_KIDX_W  = 4;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } ctrl_state_t;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Handshake and datapath bundle for aes_round_ctrl.
// The in_decrypt signal exists only when AES_DECRYPT_EN is defined.
interface aes_round_ctrl_if
   import aes_pkg::*;
#(
   parameter int DATA_W = AES_BLOCK_W,
   parameter int KIDX_W = AES_KIDX_W
);

   logic              key_we;
   logic [KIDX_W-1:0] key_waddr;
   logic [DATA_W-1:0] key_wdata;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
`ifdef AES_DECRYPT_EN
   logic              in_decrypt;
`endif

   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] rd_key;
   logic [KIDX_W-1:0] rd_round;
   logic              rd_first;
   logic              rd_last;

   logic              dp_valid;
   logic [DATA_W-1:0] dp_data;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;

   logic              busy;
   logic              err;

   modport master (
`ifdef AES_DECRYPT_EN
      input  in_decrypt,
`endif
      input  key_we, key_waddr, key_wdata,
      input  in_valid, in_data,
      input  dp_valid, dp_data,
      input  out_ready,
      output in_ready,
      output rd_valid, rd_data, rd_key, rd_round, rd_first, rd_last,
      output out_valid, out_data,
      output busy, err
   );

   modport slave (
`ifdef AES_DECRYPT_EN
      output in_decrypt,
`endif
      output key_we, key_waddr, key_wdata,
      output in_valid, in_data,
      output dp_valid, dp_data,
      output out_ready,
      input  in_ready,
      input  rd_valid, rd_data, rd_key, rd_round, rd_first, rd_last,
      input  out_valid, out_data,
      input  busy, err
   );

endinterface

// File: rtl/aes_round_key_file.sv
// Round-key storage: NENT entries, one write port, combinational read port.
module aes_round_key_file
   import aes_pkg::*;
#(
   parameter int DATA_W = AES_BLOCK_W,
   parameter int NENT   = AES_NR + 1,
   parameter int KIDX_W = AES_KIDX_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [KIDX_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [KIDX_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam logic [KIDX_W-1:0] LAST = KIDX_W'(NENT - 1);

   logic [DATA_W-1:0] mem_q [NENT];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NENT; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Indices beyond the last entry read as zero rather than X.
   assign rdata = (raddr <= LAST) ? mem_q[raddr] : '0;

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: issues NR+1 rounds to an external datapath.
// Optional AES_DECRYPT_EN adds in_decrypt, which reverses the key-index order.
//
// state | meaning
// IDLE  | ready for a block; key writes accepted
// ISSUE | one-cycle round issue to the datapath
// WAIT  | waiting for the datapath result of the issued round
// DONE  | result presented, held until out_ready
module aes_round_ctrl
   import aes_pkg::*;
#(
   parameter int DATA_W = AES_BLOCK_W,
   parameter int NR     = AES_NR,
   parameter int KIDX_W = AES_KIDX_W
) (
   input  logic             clk,
   input  logic             reset,
   aes_round_ctrl_if.master bus
);

   localparam logic [KIDX_W-1:0] NR_K  = KIDX_W'(NR);
   localparam logic [KIDX_W-1:0] ONE_K = KIDX_W'(1);

   ctrl_state_t       state_q;
   logic [DATA_W-1:0] blk_q;
   logic [KIDX_W-1:0] round_q;
   logic [KIDX_W-1:0] round_inc;
   logic [KIDX_W-1:0] kidx;
   logic              in_ready_q;
   logic              rd_valid_q;
   logic              rd_first_q;
   logic              rd_last_q;
   logic              out_valid_q;
   logic              busy_q;
   logic              err_q;
   logic              key_wr_ok;
   logic              key_wr_bad;
   logic              dp_bad;

   assign key_wr_ok  = bus.key_we && (state_q == IDLE) && (bus.key_waddr <= NR_K);
   assign key_wr_bad = bus.key_we && !key_wr_ok;
   assign dp_bad     = bus.dp_valid && (state_q != WAIT);
   assign round_inc  = round_q + ONE_K;

`ifdef AES_DECRYPT_EN
   logic dec_q;
   assign kidx = dec_q ? (NR_K - round_q) : round_q;
`else
   assign kidx = round_q;
`endif

   aes_round_key_file #(
      .DATA_W (DATA_W),
      .NENT   (NR + 1),
      .KIDX_W (KIDX_W)
   ) u_key_file (
      .clk   (clk),
      .reset (reset),
      .we    (key_wr_ok),
      .waddr (bus.key_waddr),
      .wdata (bus.key_wdata),
      .raddr (kidx),
      .rdata (bus.rd_key)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         blk_q       <= '0;
         round_q     <= '0;
         in_ready_q  <= 1'b1;
         rd_valid_q  <= 1'b0;
         rd_first_q  <= 1'b0;
         rd_last_q   <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
`ifdef AES_DECRYPT_EN
         dec_q       <= 1'b0;
`endif
      end else begin
         err_q      <= key_wr_bad | dp_bad;
         rd_valid_q <= 1'b0;
         rd_first_q <= 1'b0;
         rd_last_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  blk_q      <= bus.in_data;
                  round_q    <= '0;
                  state_q    <= ISSUE;
                  rd_valid_q <= 1'b1;
                  rd_first_q <= 1'b1;
                  rd_last_q  <= (NR_K == '0);
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
`ifdef AES_DECRYPT_EN
                  dec_q      <= bus.in_decrypt;
`endif
               end
            end
            ISSUE: begin
               state_q <= WAIT;
            end
            WAIT: begin
               if (bus.dp_valid) begin
                  blk_q <= bus.dp_data;
                  if (round_q == NR_K) begin
                     state_q     <= DONE;
                     out_valid_q <= 1'b1;
                  end else begin
                     round_q    <= round_inc;
                     state_q    <= ISSUE;
                     rd_valid_q <= 1'b1;
                     rd_last_q  <= (round_inc == NR_K);
                  end
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.rd_data   = blk_q;
   assign bus.rd_round  = round_q;
   assign bus.rd_first  = rd_first_q;
   assign bus.rd_last   = rd_last_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = blk_q;
   assign bus.busy      = busy_q;
   assign bus.err       = err_q;

endmodule
